// File: rtl/hdd_pwr_seq_pkg.sv
// Shared constants and FSM encoding for the staggered HDD power sequencer.
package hdd_pwr_seq_pkg;

    localparam int unsigned NUM_HDD            = 15;
    localparam int unsigned PTR_W              = $clog2(NUM_HDD);
    localparam int unsigned DEF_TICK_DIV       = 25000;
    localparam int unsigned DEF_DEBOUNCE_TICKS = 16;
    localparam int unsigned DEF_PG_TIMEOUT     = 200;
    localparam int unsigned DEF_STAGGER_TICKS  = 500;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCAN    = 3'd1,
        ST_ENABLE  = 3'd2,
        ST_WAIT_PG = 3'd3,
        ST_STAGGER = 3'd4
    } seq_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hdd_pwr_seq_debounce.sv
// One-bit insert debouncer: synchronises the raw pin and accepts a new level
// only after DEBOUNCE_TICKS consecutive tick samples that disagree with the current one.
module hdd_pwr_seq_debounce #(
    parameter int unsigned DEBOUNCE_TICKS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            if (tick_i) begin
                if (sync_q[1] == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/hdd_pwr_seq.sv
// Staggered HDD power sequencer: debounces bay presence, powers one bay at a time
// with a power-good timeout and inrush spacing, and latches per-bay power faults.
module hdd_pwr_seq
    import hdd_pwr_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
    parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int unsigned PG_TIMEOUT     = DEF_PG_TIMEOUT,
    parameter int unsigned STAGGER_TICKS  = DEF_STAGGER_TICKS
) (
    input  logic               SYSCLK,
    input  logic               RESET_N,
    input  logic               seq_en,
    input  logic [NUM_HDD-1:0] hdd_insert_l,
    input  logic [NUM_HDD-1:0] p5v_gd,
    input  logic [NUM_HDD-1:0] p12v_gd,
    input  logic [NUM_HDD-1:0] pwr_allow,
    input  logic [NUM_HDD-1:0] fault_clr,
    output logic [NUM_HDD-1:0] pwr_en_l,
    output logic [NUM_HDD-1:0] hdd_present,
    output logic [NUM_HDD-1:0] hdd_pwr_ok,
    output logic [NUM_HDD-1:0] hdd_fault,
    output logic               seq_busy
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV + 1);
    localparam int unsigned TMR_W = $clog2(max_u(PG_TIMEOUT, STAGGER_TICKS) + 1);

    logic [PRE_W-1:0]   pre_q;
    logic               tick_q;
    seq_state_e         state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [TMR_W-1:0]   timer_q;
    logic               seq_busy_q;
    logic [NUM_HDD-1:0] pwr_en_l_q, pwr_en_l_d;
    logic [NUM_HDD-1:0] fault_q, fault_d;
    logic [NUM_HDD-1:0] pwr_ok_q;
    logic [NUM_HDD-1:0] pg_bad_q;

    logic [NUM_HDD-1:0] pg_both_c, eligible_c, in_wait_c, pg_bad_c, trip_c, shut_c, fault_set_c;
    logic [PTR_W-1:0]   ptr_inc_c;
    logic               lost_c, timeout_c;

    // Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else if (pre_q == PRE_W'(TICK_DIV - 1)) begin
            pre_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            pre_q  <= pre_q + PRE_W'(1);
            tick_q <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_HDD; g++) begin : g_deb
        hdd_pwr_seq_debounce #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
        ) u_deb (
            .clk     (SYSCLK),
            .rst_n   (RESET_N),
            .tick_i  (tick_q),
            .raw_i   (~hdd_insert_l[g]),
            .level_o (hdd_present[g])
        );
    end

    // Power-off paths (removal, revoked permission, lost power-good) act on every bay
    // directly; the FSM only ever turns on the bay under its pointer.
    always_comb begin
        pg_both_c   = p5v_gd & p12v_gd;
        eligible_c  = hdd_present & pwr_allow & ~fault_q & pwr_en_l_q;
        ptr_inc_c   = (ptr_q == PTR_W'(NUM_HDD - 1)) ? '0 : ptr_q + PTR_W'(1);
        lost_c      = ~hdd_present[ptr_q] | ~pwr_allow[ptr_q];
        for (int n = 0; n < NUM_HDD; n++) begin
            in_wait_c[n] = (state_q == ST_WAIT_PG) && (ptr_q == PTR_W'(n));
        end
        pg_bad_c    = ~pwr_en_l_q & ~pg_both_c & ~in_wait_c;
        trip_c      = pg_bad_c & pg_bad_q;
        shut_c      = ~pwr_en_l_q & ~(hdd_present & pwr_allow);
        timeout_c   = seq_en && (state_q == ST_WAIT_PG) && !lost_c && !pg_both_c[ptr_q]
                      && (timer_q == TMR_W'(PG_TIMEOUT));
        pwr_en_l_d  = pwr_en_l_q | shut_c | trip_c;
        fault_set_c = trip_c;
        if (timeout_c) begin
            pwr_en_l_d[ptr_q]  = 1'b1;
            fault_set_c[ptr_q] = 1'b1;
        end
        if (seq_en && (state_q == ST_ENABLE)) begin
            pwr_en_l_d[ptr_q] = 1'b0;
        end
        if (!seq_en) begin
            pwr_en_l_d = '1;
        end
        fault_d = (fault_q & ~fault_clr) | fault_set_c;
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pwr_en_l_q <= '1;
            fault_q    <= '0;
            pwr_ok_q   <= '0;
            pg_bad_q   <= '0;
        end else begin
            pwr_en_l_q <= pwr_en_l_d;
            fault_q    <= fault_d;
            pwr_ok_q   <= ~pwr_en_l_q & pg_both_c;
            pg_bad_q   <= pg_bad_c;
        end
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            timer_q    <= '0;
            seq_busy_q <= 1'b0;
        end else if (!seq_en) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            timer_q    <= '0;
            seq_busy_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (eligible_c[ptr_q]) begin
                        state_q    <= ST_ENABLE;
                        seq_busy_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_inc_c;
                    end
                end
                ST_ENABLE: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT_PG;
                end
                ST_WAIT_PG: begin
                    if (lost_c) begin
                        timer_q    <= '0;
                        state_q    <= ST_SCAN;
                        seq_busy_q <= 1'b0;
                    end else if (pg_both_c[ptr_q] || (timer_q == TMR_W'(PG_TIMEOUT))) begin
                        timer_q <= '0;
                        state_q <= ST_STAGGER;
                    end else if (tick_q) begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_STAGGER: begin
                    if (timer_q == TMR_W'(STAGGER_TICKS)) begin
                        timer_q    <= '0;
                        ptr_q      <= ptr_inc_c;
                        state_q    <= ST_SCAN;
                        seq_busy_q <= 1'b0;
                    end else if (tick_q) begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    seq_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign pwr_en_l   = pwr_en_l_q;
    assign hdd_pwr_ok = pwr_ok_q;
    assign hdd_fault  = fault_q;
    assign seq_busy   = seq_busy_q;

endmodule
